// File: rtl/range_ctrl_pkg.sv
// range_ctrl_pkg: shared state type and defaults for the range-check scheduler
package range_ctrl_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_VEC_LEN = 12;
    // Bound defaults are truncated to the element width where used: lower = 0, upper = all ones
    localparam logic [31:0] DEF_LOWER = '0;
    localparam logic [31:0] DEF_UPPER = '1;
    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;
endpackage

// File: rtl/range_check_scheduler_rr_arbiter.sv
// rr_arbiter: combinational one-hot round-robin pick, searching upward from ptr with wrap
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant
);
    // Walk from the farthest candidate back to ptr so the nearest requester wins
    always_comb begin
        grant = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[ID_W'((int'(ptr) + k) % NUM_REQ)]) begin
                grant = '0;
                grant[ID_W'((int'(ptr) + k) % NUM_REQ)] = 1'b1;
            end
    end
endmodule

// File: rtl/range_check_scheduler.sv
// range_check_scheduler: round-robin sharing of one serial range-check datapath among requesters
module range_check_scheduler
    import range_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int VEC_LEN = DEF_VEC_LEN,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ID_W = $clog2(NUM_REQ)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        cfg_we,
    input  logic [ID_W-1:0]             cfg_id,
    input  logic [DATA_W-1:0]           cfg_lower,
    input  logic [DATA_W-1:0]           cfg_upper,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*VEC_LEN*DATA_W-1:0] req_vector,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [VEC_LEN*DATA_W-1:0]   rsp_vector,
    output logic [VEC_LEN-1:0]          rsp_error,
    output logic                        busy
);
    localparam int SLICE_W = VEC_LEN * DATA_W;
    localparam int IDX_W = $clog2(VEC_LEN);
    localparam int VEC_BITS = $clog2(SLICE_W);
    localparam int REQ_BITS = $clog2(NUM_REQ * SLICE_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

    state_t state, nextState;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0] ptr, grantId, rspId;
    logic [DATA_W-1:0] lowerBound [NUM_REQ];
    logic [DATA_W-1:0] upperBound [NUM_REQ];
    logic [DATA_W-1:0] capLower, capUpper, elem;
    logic [SLICE_W-1:0] capVec, resVec;
    logic [VEC_LEN-1:0] resErr;
    logic [IDX_W-1:0] idx;
    logic [VEC_BITS-1:0] elemBase;
    logic [REQ_BITS-1:0] grantBase;
    logic accept, elemPass;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) arbiter (
        .req(req_valid),
        .ptr(ptr),
        .grant(grant)
    );

    // Encode the one-hot winner as a requester id
    always_comb begin
        grantId = '0;
        for (int r = 0; r < NUM_REQ; r++)
            if (grant[r]) grantId = ID_W'(r);
    end

    assign accept = |req_ready;
    assign grantBase = REQ_BITS'(grantId * SLICE_W);
    assign elemBase = VEC_BITS'(idx * DATA_W);
    assign elem = capVec[elemBase +: DATA_W];
    // Strict on both sides, so an empty or inverted window rejects everything
    assign elemPass = (elem > capLower) && (elem < capUpper);

    // State register
    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else state <= nextState;

    // Next-state logic: accept -> scan all elements -> wait for consumer
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = accept ? CHECK : IDLE;
            CHECK:   nextState = (idx == LAST_IDX) ? RESP : CHECK;
            RESP:    nextState = rsp_ready ? IDLE : RESP;
            default: nextState = IDLE;
        endcase
    end

    // Outputs decoded from state; grants are only offered while idle and out of reset
    always_comb begin
        req_ready = (state == IDLE && !reset) ? grant : '0;
        rsp_valid = state == RESP;
        busy = state != IDLE;
    end

    // Per-requester bounds, writable in any state; ids without a requester match nothing
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                lowerBound[r] <= DATA_W'(DEF_LOWER);
                upperBound[r] <= DATA_W'(DEF_UPPER);
            end
        end else if (cfg_we) begin
            for (int r = 0; r < NUM_REQ; r++)
                if (cfg_id == ID_W'(r)) begin
                    lowerBound[r] <= cfg_lower;
                    upperBound[r] <= cfg_upper;
                end
        end

    // Capture vector and bound snapshot on accept, then resolve one element per CHECK cycle
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            ptr <= '0;
            rspId <= '0;
            idx <= '0;
            capVec <= '0;
            capLower <= '0;
            capUpper <= '0;
            resVec <= '0;
            resErr <= '0;
        end else if (accept) begin
            capVec <= req_vector[grantBase +: SLICE_W];
            capLower <= lowerBound[grantId];
            capUpper <= upperBound[grantId];
            rspId <= grantId;
            idx <= '0;
            resVec <= '0;
            resErr <= '0;
            ptr <= (grantId == ID_W'(NUM_REQ - 1)) ? '0 : grantId + 1'b1;
        end else if (state == CHECK) begin
            resVec[elemBase +: DATA_W] <= elemPass ? elem : '0;
            resErr[idx] <= !elemPass;
            idx <= idx + 1'b1;
        end

    assign rsp_id = rspId;
    assign rsp_vector = resVec;
    assign rsp_error = resErr;
endmodule

// File: tb/tb_range_check_scheduler.sv
// tb_range_check_scheduler: randomized and directed stimulus against a behavioural scoreboard model
module tb_range_check_scheduler;
    import range_ctrl_pkg::*;
    localparam int N = 4;
    localparam int L = DEF_VEC_LEN;
    localparam int W = DEF_DATA_W;
    localparam int IW = $clog2(N);
    localparam int SW = L * W;

    logic clock = 0;
    logic reset = 1;
    logic cfg_we = 0;
    logic [IW-1:0] cfg_id = '0;
    logic [W-1:0] cfg_lower = '0;
    logic [W-1:0] cfg_upper = '0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready;
    logic [N*SW-1:0] req_vector = '0;
    logic rsp_valid;
    logic rsp_ready = 0;
    logic [IW-1:0] rsp_id;
    logic [SW-1:0] rsp_vector;
    logic [L-1:0] rsp_error;
    logic busy;

    range_check_scheduler #(.NUM_REQ(N), .VEC_LEN(L), .DATA_W(W)) dut (
        .clock(clock),
        .reset(reset),
        .cfg_we(cfg_we),
        .cfg_id(cfg_id),
        .cfg_lower(cfg_lower),
        .cfg_upper(cfg_upper),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_vector(req_vector),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_vector(rsp_vector),
        .rsp_error(rsp_error),
        .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int id;
        logic [SW-1:0] vec;
        logic [L-1:0] err;
    } exp_t;

    exp_t sbq[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit mBusy = 0;
    bit rrMode = 0;
    int mAcc = 0;
    int mPtr = 0;
    int lastAcc = -1;
    int rrCount = 0;
    logic [W-1:0] mLo [N];
    logic [W-1:0] mHi [N];

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endfunction

    function automatic void resetModel();
        mBusy = 0;
        mPtr = 0;
        lastAcc = -1;
        sbq.delete();
        for (int r = 0; r < N; r++) begin
            mLo[r] = '0;
            mHi[r] = '1;
        end
    endfunction

    function automatic logic [SW-1:0] randVec();
        logic [SW-1:0] v;
        for (int i = 0; i < L; i++) v[i*W +: W] = W'($urandom_range(0, 255));
        return v;
    endfunction

    initial resetModel();

    // Reference model: predicts grants, busy and response timing; queues the expected result of each accept
    always @(negedge clock) begin
        int g;
        logic [N-1:0] expReady;
        bit expRsp;
        exp_t e;
        g = -1;
        expReady = '0;
        if (reset) begin
            resetModel();
            chk("reset_req_ready", req_ready, 0);
            chk("reset_busy", busy, 0);
            chk("reset_rsp_valid", rsp_valid, 0);
            chk("reset_rsp_id", rsp_id, 0);
            chk("reset_rsp_vector", rsp_vector, 0);
            chk("reset_rsp_error", rsp_error, 0);
        end else begin
            for (int k = 0; k < N; k++)
                if (!mBusy && g < 0 && req_valid[(mPtr + k) % N]) g = (mPtr + k) % N;
            if (g >= 0) expReady[g] = 1'b1;
            expRsp = mBusy && (cyc - mAcc >= L);
            chk("req_ready", req_ready, expReady);
            chk("busy", busy, mBusy);
            chk("rsp_valid", rsp_valid, expRsp);
            if (expRsp && rsp_ready) mBusy = 0;
            if (g >= 0) begin
                e.id = g;
                e.vec = req_vector[g*SW +: SW];
                e.err = '0;
                for (int i = 0; i < L; i++)
                    if (!(mLo[g] < e.vec[i*W +: W] && e.vec[i*W +: W] < mHi[g])) begin
                        e.vec[i*W +: W] = '0;
                        e.err[i] = 1'b1;
                    end
                sbq.push_back(e);
                if (rrMode) begin
                    chk("rr_order", g, rrCount % N);
                    if (lastAcc >= 0) chk("rr_spacing", cyc + 1 - lastAcc, L + 2);
                    lastAcc = cyc + 1;
                    rrCount++;
                end
                mAcc = cyc + 1;
                mBusy = 1;
                mPtr = (g + 1) % N;
            end
            if (cfg_we && int'(cfg_id) < N) begin
                mLo[cfg_id] = cfg_lower;
                mHi[cfg_id] = cfg_upper;
            end
        end
    end

    // Scoreboard monitor: every presented response must equal the oldest expected one
    always @(negedge clock) begin
        if (!reset && rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got response id %0d, expected none", rsp_id);
            end else begin
                chk("rsp_id", rsp_id, sbq[0].id);
                chk("rsp_vector", rsp_vector, sbq[0].vec);
                chk("rsp_error", rsp_error, sbq[0].err);
                if (rsp_ready) void'(sbq.pop_front());
            end
        end
    end

    task automatic setVec(input int r, input logic [SW-1:0] v);
        req_vector[r*SW +: SW] = v;
    endtask

    task automatic cfgWrite(input int id, input int lo, input int hi);
        cfg_we = 1;
        cfg_id = IW'(id);
        cfg_lower = W'(lo);
        cfg_upper = W'(hi);
        @(posedge clock);
        #1;
        cfg_we = 0;
    endtask

    task automatic acceptAll(input logic [N-1:0] mask);
        logic [N-1:0] acc;
        req_valid = mask;
        for (int t = 0; t < 200 && req_valid !== '0; t++) begin
            @(negedge clock);
            acc = req_ready;
            @(posedge clock);
            #1;
            req_valid = req_valid & ~acc;
        end
        if (req_valid !== '0) timeout("accept");
        req_valid = '0;
    endtask

    task automatic waitIdle();
        bit done = 0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clock);
            done = (busy === 1'b0);
        end
        if (!done) timeout("idle");
        @(posedge clock);
        #1;
    endtask

    task automatic waitRsp();
        bit done = 0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clock);
            done = (rsp_valid === 1'b1);
        end
        if (!done) timeout("rsp_valid");
        @(posedge clock);
        #1;
    endtask

    task automatic serve(input logic [N-1:0] mask);
        acceptAll(mask);
        waitIdle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SW-1:0] v;
        logic [SW-1:0] v2;
        req_valid = '1;
        repeat (3) @(posedge clock);
        #1;
        req_valid = '0;
        reset = 0;
        rsp_ready = 1;
        // Default bounds: only element 0 (equal to lower) fails
        for (int i = 0; i < L; i++) v[i*W +: W] = W'(i);
        setVec(0, v);
        serve(4'b0001);
        chk("t1_error", rsp_error, 12'h001);
        chk("t1_elem0", rsp_vector[0 +: W], 0);
        chk("t1_elem5", rsp_vector[5*W +: W], 5);
        // Window (10,20): only 15 passes
        cfgWrite(1, 10, 20);
        for (int i = 0; i < L; i++) v[i*W +: W] = (i % 3 == 0) ? W'(10) : (i % 3 == 1) ? W'(15) : W'(20);
        setVec(1, v);
        serve(4'b0010);
        chk("t2_error", rsp_error, 12'hB6D);
        chk("t2_elem1", rsp_vector[W +: W], 15);
        chk("t2_elem2", rsp_vector[2*W +: W], 0);
        // Bound write during CHECK affects only the next vector
        for (int i = 0; i < L; i++) v[i*W +: W] = W'(30 + 4 * i);
        setVec(2, v);
        acceptAll(4'b0100);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        cfgWrite(2, 50, 40);
        waitIdle();
        chk("cfg_old_bounds", rsp_error, 12'h000);
        setVec(2, randVec());
        serve(4'b0100);
        chk("cfg_new_bounds", rsp_error, 12'hFFF);
        chk("cfg_new_vector", rsp_vector, 0);
        // Stalled response with other requesters waiting
        setVec(3, randVec());
        rsp_ready = 0;
        acceptAll(4'b1000);
        req_valid = 4'b0111;
        waitRsp();
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        req_valid = '0;
        rsp_ready = 1;
        waitIdle();
        // All requesters continuously valid
        rrCount = 0;
        lastAcc = -1;
        rrMode = 1;
        req_valid = '1;
        repeat (9 * (L + 2)) begin
            @(posedge clock);
            #1;
            req_vector = {randVec(), randVec(), randVec(), randVec()};
        end
        req_valid = '0;
        waitIdle();
        rrMode = 0;
        chk("rr_accepts", rrCount, 9);
        // Reset in the middle of CHECK
        setVec(1, randVec());
        acceptAll(4'b0010);
        repeat (5) begin
            @(posedge clock);
            #1;
        end
        reset = 1;
        #1;
        chk("rst_busy_now", busy, 0);
        chk("rst_rsp_valid_now", rsp_valid, 0);
        @(posedge clock);
        #1;
        reset = 0;
        for (int i = 0; i < L; i++) v[i*W +: W] = W'(20 * i);
        for (int i = 0; i < L; i++) v2[i*W +: W] = (i == 0) ? W'(0) : (i == L - 1) ? W'(255) : W'(100 + i);
        setVec(0, v);
        setVec(2, v2);
        serve(4'b0101);
        chk("post_rst_last_id", rsp_id, 2);
        chk("post_rst_error", rsp_error, 12'h801);
        // Randomized traffic, bound writes, backpressure and occasional resets
        for (int c = 0; c < 600; c++) begin
            @(posedge clock);
            #1;
            req_valid = N'($urandom);
            req_vector = {randVec(), randVec(), randVec(), randVec()};
            rsp_ready = ($urandom_range(0, 3) != 0);
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_id = IW'($urandom);
            cfg_lower = W'($urandom_range(0, 120));
            cfg_upper = W'($urandom_range(100, 255));
            reset = ($urandom_range(0, 199) == 0);
        end
        req_valid = '0;
        cfg_we = 0;
        reset = 0;
        rsp_ready = 1;
        waitIdle();
        chk("drain_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/range_check_scheduler.md
# range_check_scheduler

Sequences one shared serial range-check datapath among several requesters. Each requester owns a programmable (lower, upper) bound pair. The scheduler grants one requester at a time round-robin and captures its 12-element vector. It checks one element per cycle against that requester's bounds, then returns the masked vector and per-element error flags through a valid/ready response channel. It sits between the vector producers and the downstream consumers of range-checked data.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- VEC_LEN, 12, elements per vector
- DATA_W, 8, element and bound width (unsigned)
- ID_W, $clog2(NUM_REQ), requester id width
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cfg_we  in  1  bound write strobe
- cfg_id  in  ID_W  requester whose bounds are written
- cfg_lower  in  DATA_W  new lower bound
- cfg_upper  in  DATA_W  new upper bound
- req_valid  in  NUM_REQ  per-requester vector valid
- req_ready  out  NUM_REQ  one-hot grant/accept
- req_vector  in  NUM_REQ*VEC_LEN*DATA_W  requester r slice at [r*VEC_LEN*DATA_W +: VEC_LEN*DATA_W]; element i at [i*DATA_W +: DATA_W] within the slice
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  requester the result belongs to
- rsp_vector  out  VEC_LEN*DATA_W  element passed through if in range, else 0
- rsp_error  out  VEC_LEN  bit i = 1 if element i out of range
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, CHECK, RESP.
- **IDLE**
  - req_ready is the combinational one-hot round-robin winner among req_valid, searched from pointer ptr upward with wrap.
  - On the edge with req_valid[g] & req_ready[g]:
    - capture vector slice g, id g, and the bounds snapshot of g
    - clear result registers; idx <= 0; ptr <= (g+1) mod NUM_REQ
    - go to CHECK
- **CHECK**
  - Each edge evaluates element idx: pass iff lower < x < upper (strict, unsigned).
  - Pass: result[idx] = x, err[idx] = 0.
  - Fail: result[idx] = 0, err[idx] = 1.
  - idx increments; after idx = VEC_LEN-1, go to RESP.
- **RESP**
  - rsp_valid = 1; rsp_id, rsp_vector and rsp_error are stable.
  - On rsp_ready, go to IDLE.
- req_ready = 0 outside IDLE.
- Bounds:
  - Reset value lower = 0, upper = 2^DATA_W-1 for every requester.
  - If lower >= upper, every element fails.
  - Equality with either bound fails.
- cfg writes are accepted in any state and affect only later accepts.
  - A write to g in the same cycle g is accepted: the snapshot takes the old bounds.
  - A cfg_id >= NUM_REQ write is ignored.
- Simultaneous valid from several requesters: only the round-robin winner is served; the others wait. A requester may drop req_valid before it is granted.

## Timing
- Reset values:
  - req_ready = 0 while reset is asserted; IDLE grant behaviour resumes after release.
  - rsp_valid = 0, rsp_id = 0, rsp_vector = 0, rsp_error = 0, busy = 0.
  - ptr = 0, all bounds at their default values.
- Latency: with accept at edge E0, CHECK runs on edges E1..E12 and rsp_valid is high after E12, i.e. VEC_LEN edges after accept.
- With rsp_ready held high, RESP lasts 1 cycle. Back-to-back service is one vector per VEC_LEN+2 cycles.
- rsp_vector and rsp_error are meaningful only while rsp_valid = 1. They hold their values after the handshake until the next accept clears them.
- Reset mid-operation: the in-flight vector is discarded with no response, all state returns to its reset values, and bounds return to their defaults.

## Structure
- Package range_ctrl_pkg holds:
  - the state enum (IDLE, CHECK, RESP)
  - DATA_W and VEC_LEN defaults
  - the default bound constants
- Sub-module rr_arbiter(NUM_REQ): inputs req, ptr, output one-hot grant; purely combinational.
- Bound registers, capture buffer, idx counter and FSM live in the top.

## Test plan
- Reset defaults, requester 0 sends elements 0,1,...,11 (element i = i): rsp_error = 0x001 (only element 0 fails); rsp_vector element 0 = 0, others equal input; rsp_valid asserted exactly 12 cycles after accept.
- Requester 1 bounds (10,20), vector all 10,15,20 repeating: elements equal to 15 pass; 10 and 20 flag errors and output 0.
- All four requesters assert valid continuously with rsp_ready = 1: grants are 0,1,2,3,0,...; consecutive accepts are 14 cycles apart; rsp_id matches the grant order.
- Hold rsp_ready = 0 for 5 cycles in RESP: outputs stay stable, no req_ready is asserted, and the response completes on the first rsp_ready.
- cfg write to requester 2 (lower 50, upper 40) during its CHECK: the current result uses the old bounds; the next vector from 2 returns rsp_error = 0xFFF.
- Assert reset at CHECK idx 5: rsp_valid stays 0 and busy drops immediately; after release, ptr = 0 and bounds are back to their defaults.
